// File: rtl/control_sequencer_if.sv
// Coprocessor start/ready/abort handshake bundle shared by the sequencer and its channels.
// The sequencer takes the master side; coprocessor channels take the slave side.
interface control_sequencer_if #(
   parameter int unsigned NUM_COP = 3
) ();

   logic [NUM_COP-1:0] cop_start;
   logic [NUM_COP-1:0] cop_abort;
   logic [NUM_COP-1:0] cop_ready;

   modport master (
      output cop_start,
      output cop_abort,
      input  cop_ready
   );

   modport slave (
      input  cop_start,
      input  cop_abort,
      output cop_ready
   );

endinterface

// File: rtl/control_sequencer.sv
// Fetch/execute phase sequencer and datapath control-word decoder, with a watchdog-guarded
// coprocessor start/ready handshake, memory stall and halt/resume.
module control_sequencer #(
   parameter int unsigned        OP_W    = 4,
   parameter int unsigned        NUM_COP = 3,
   parameter int unsigned        TO_W    = 8,
   parameter logic [NUM_COP-1:0] COP_WB  = NUM_COP'(3'b110)
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [OP_W-1:0]            op,
   input  logic                       eq,
   input  logic                       mi,
   input  logic                       stall,
   input  logic                       resume,
   control_sequencer_if.master        cop,
   output logic [11:0]                control_port,
   output logic                       fetch,
   output logic                       exec1,
   output logic                       exec2,
   output logic                       waiting,
   output logic                       halted,
   output logic                       err_timeout,
   output logic                       illegal_op
);

   localparam int unsigned OpLda   = 0;
   localparam int unsigned OpSta   = 1;
   localparam int unsigned OpAdd   = 2;
   localparam int unsigned OpSub   = 3;
   localparam int unsigned OpJmp   = 4;
   localparam int unsigned OpJmi   = 5;
   localparam int unsigned OpJeq   = 6;
   localparam int unsigned OpStp   = 7;
   localparam int unsigned OpLdi   = 8;
   localparam int unsigned OpLsl   = 9;
   localparam int unsigned OpLsr   = 10;
   localparam int unsigned CopBase = 11;

   localparam logic [TO_W-1:0] WdMax = '1;

   typedef enum logic [2:0] {
      StFetch,
      StExec1,
      StExec2,
      StWait,
      StHalt
   } state_e;

   state_e            state_q, state_d;
   logic [TO_W-1:0]   wd_q, wd_d;
   logic              err_q, err_d;
   // Remembers that the current COP instruction left WAIT by timeout, to drop its writeback.
   logic              to_q, to_d;

   int unsigned        op_val;
   logic               is_lda, is_sta, is_add, is_sub, is_jmp, is_jmi, is_jeq, is_stp;
   logic               is_ldi, is_lsl, is_lsr, is_cop, is_ill;
   logic [NUM_COP-1:0] cop_hit;
   logic               ready_sel, wb_sel, expire;
   logic [NUM_COP-1:0] cop_start_w, cop_abort_w;

   // Opcode decode; cop_hit is the one-hot channel selected by a COP_k opcode.
   always_comb begin
      op_val = 32'(op);
      is_lda = (op_val == OpLda);
      is_sta = (op_val == OpSta);
      is_add = (op_val == OpAdd);
      is_sub = (op_val == OpSub);
      is_jmp = (op_val == OpJmp);
      is_jmi = (op_val == OpJmi);
      is_jeq = (op_val == OpJeq);
      is_stp = (op_val == OpStp);
      is_ldi = (op_val == OpLdi);
      is_lsl = (op_val == OpLsl);
      is_lsr = (op_val == OpLsr);
      cop_hit = '0;
      for (int unsigned k = 0; k < NUM_COP; k++) begin
         cop_hit[k] = (op_val == CopBase + k);
      end
      is_cop    = |cop_hit;
      is_ill    = (op_val >= CopBase + NUM_COP);
      ready_sel = |(cop.cop_ready & cop_hit);
      wb_sel    = |(COP_WB & cop_hit);
   end

   // Ready wins over expiry when both happen in the same WAIT cycle.
   assign expire = (state_q == StWait) && !ready_sel && (wd_q == WdMax);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StFetch;
         wd_q    <= '0;
         err_q   <= 1'b0;
         to_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         wd_q    <= wd_d;
         err_q   <= err_d;
         to_q    <= to_d;
      end
   end

   always_comb begin
      state_d = state_q;
      wd_d    = wd_q;
      err_d   = err_q;
      to_d    = to_q;
      if (!stall) begin
         unique case (state_q)
            StFetch: state_d = StExec1;
            StExec1: begin
               if (is_lda || is_add || is_sub) begin
                  state_d = StExec2;
               end else if (is_cop) begin
                  state_d = StWait;
                  wd_d    = '0;
                  to_d    = 1'b0;
               end else if (is_stp) begin
                  state_d = StHalt;
               end else begin
                  state_d = StFetch;
               end
            end
            StExec2: state_d = StFetch;
            StWait: begin
               if (ready_sel) begin
                  state_d = StExec2;
               end else if (wd_q == WdMax) begin
                  state_d = StExec2;
                  to_d    = 1'b1;
                  err_d   = 1'b1;
               end else begin
                  wd_d = wd_q + TO_W'(1);
               end
            end
            StHalt: begin
               if (resume) begin
                  state_d = StFetch;
               end
            end
            default: state_d = StFetch;
         endcase
      end
   end

   always_comb begin
      logic fe, e1, e2, ha;
      logic acc_wr;
      logic [11:0] ctl;

      fe = (state_q == StFetch);
      e1 = (state_q == StExec1);
      e2 = (state_q == StExec2);
      ha = (state_q == StHalt);

      acc_wr = (e2 && (is_lda || is_add || is_sub || (is_cop && wb_sel && !to_q)))
            || (e1 && (is_ldi || is_lsl || is_lsr));

      ctl     = '0;
      ctl[0]  = e1 && is_sta;
      ctl[1]  = fe;
      ctl[2]  = (e1 && (is_sta || (is_jmi && !mi) || (is_jeq && !eq) || is_ldi || is_lsl
                        || is_lsr || is_ill))
             || (e2 && (is_lda || is_add || is_sub || is_cop))
             || (ha && resume);
      ctl[3]  = e1 && (is_jmp || (is_jmi && mi) || (is_jeq && eq));
      ctl[4]  = (e2 && is_add) || (e1 && is_lsl);
      ctl[5]  = acc_wr;
      ctl[6]  = 1'b0;
      ctl[7]  = acc_wr && !(e1 && is_lsr);
      ctl[8]  = e1 && (is_lda || is_sta || is_add || is_sub || is_jmp || (is_jmi && mi)
                       || (is_jeq && eq) || is_cop);
      ctl[9]  = e1 && is_lsl;
      ctl[10] = (e2 && is_lda) || (e1 && is_ldi);
      ctl[11] = e2 && is_lda;

      control_port = stall ? 12'h000 : ctl;
      cop_start_w  = (e1 && !stall) ? cop_hit : '0;
      cop_abort_w  = (expire && !stall) ? cop_hit : '0;
      illegal_op   = e1 && is_ill && !stall;

      fetch   = fe;
      exec1   = e1;
      exec2   = e2;
      waiting = (state_q == StWait);
      halted  = ha;
   end

   assign cop.cop_start = cop_start_w;
   assign cop.cop_abort = cop_abort_w;
   assign err_timeout   = err_q;

endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench for control_sequencer: each driven cycle pushes its expected outputs,
// a negedge checker pops and compares them against the DUT.
module tb_control_sequencer;

   localparam logic [4:0] PF = 5'b10000;
   localparam logic [4:0] PE1 = 5'b01000;
   localparam logic [4:0] PE2 = 5'b00100;
   localparam logic [4:0] PW = 5'b00010;
   localparam logic [4:0] PH = 5'b00001;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic [3:0]  op = '0;
   logic        eq = 1'b0;
   logic        mi = 1'b0;
   logic        stall = 1'b0;
   logic        resume = 1'b0;
   logic [11:0] control_port;
   logic        fetch, exec1, exec2, waiting, halted, err_timeout, illegal_op;

   control_sequencer_if #(.NUM_COP(3)) cop_if ();

   control_sequencer #(
      .OP_W    (4),
      .NUM_COP (3),
      .TO_W    (3),
      .COP_WB  (3'b110)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .op           (op),
      .eq           (eq),
      .mi           (mi),
      .stall        (stall),
      .resume       (resume),
      .cop          (cop_if),
      .control_port (control_port),
      .fetch        (fetch),
      .exec1        (exec1),
      .exec2        (exec2),
      .waiting      (waiting),
      .halted       (halted),
      .err_timeout  (err_timeout),
      .illegal_op   (illegal_op)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          id;
      logic [4:0]  ph;
      logic [11:0] ctl;
      logic [2:0]  start;
      logic [2:0]  abort;
      logic        err;
      logic        ill;
   } exp_t;

   exp_t exp_q[$];
   int   n_cmp = 0;
   int   n_bad = 0;
   int   n_step = 0;
   logic exp_err = 1'b0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   // Drives one cycle's inputs, records what that cycle must show, then advances a clock.
   task automatic step(input logic [3:0] a_op, input logic a_eq, input logic a_mi,
                       input logic a_stall, input logic a_res, input logic [2:0] a_rdy,
                       input logic [4:0] e_ph, input logic [11:0] e_ctl,
                       input logic [2:0] e_start, input logic [2:0] e_abort, input logic e_ill);
      exp_t e;
      op = a_op;
      eq = a_eq;
      mi = a_mi;
      stall = a_stall;
      resume = a_res;
      cop_if.cop_ready = a_rdy;
      e.id = n_step;
      e.ph = e_ph;
      e.ctl = e_ctl;
      e.start = e_start;
      e.abort = e_abort;
      e.err = exp_err;
      e.ill = e_ill;
      exp_q.push_back(e);
      n_step++;
      @(posedge clk);
      #1;
   endtask

   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check($sformatf("c%0d.phase", e.id),
                  32'({fetch, exec1, exec2, waiting, halted}), 32'(e.ph));
            check($sformatf("c%0d.ctl", e.id), 32'(control_port), 32'(e.ctl));
            check($sformatf("c%0d.start", e.id), 32'(cop_if.cop_start), 32'(e.start));
            check($sformatf("c%0d.abort", e.id), 32'(cop_if.cop_abort), 32'(e.abort));
            check($sformatf("c%0d.err", e.id), 32'(err_timeout), 32'(e.err));
            check($sformatf("c%0d.ill", e.id), 32'(illegal_op), 32'(e.ill));
         end
      end
   end

   task automatic check_reset(input string tag);
      check({tag, ".phase"}, 32'({fetch, exec1, exec2, waiting, halted}), 32'(PF));
      check({tag, ".ctl"}, 32'(control_port), 32'h002);
      check({tag, ".start"}, 32'(cop_if.cop_start), 32'h0);
      check({tag, ".abort"}, 32'(cop_if.cop_abort), 32'h0);
      check({tag, ".err"}, 32'(err_timeout), 32'h0);
      check({tag, ".ill"}, 32'(illegal_op), 32'h0);
   endtask

   initial begin
      cop_if.cop_ready = '0;
      #1 rst_n = 1'b0;
      #2 check_reset("reset");
      @(posedge clk);
      #1 rst_n = 1'b1;

      // op eq mi stall resume ready | phase ctl start abort ill
      // LDA
      step(4'd0, 0, 0, 0, 0, 3'b000, PF, 12'h002, 3'b000, 3'b000, 0);
      step(4'd0, 0, 0, 0, 0, 3'b000, PE1, 12'h100, 3'b000, 3'b000, 0);
      step(4'd0, 0, 0, 0, 0, 3'b000, PE2, 12'hCA4, 3'b000, 3'b000, 0);
      // JEQ taken, then not taken
      step(4'd6, 1, 0, 0, 0, 3'b000, PF, 12'h002, 3'b000, 3'b000, 0);
      step(4'd6, 1, 0, 0, 0, 3'b000, PE1, 12'h108, 3'b000, 3'b000, 0);
      step(4'd6, 0, 0, 0, 0, 3'b000, PF, 12'h002, 3'b000, 3'b000, 0);
      step(4'd6, 0, 0, 0, 0, 3'b000, PE1, 12'h004, 3'b000, 3'b000, 0);
      // COP_1, ready rises on the third WAIT cycle
      step(4'd12, 0, 0, 0, 0, 3'b000, PF, 12'h002, 3'b000, 3'b000, 0);
      step(4'd12, 0, 0, 0, 0, 3'b000, PE1, 12'h100, 3'b010, 3'b000, 0);
      step(4'd12, 0, 0, 0, 0, 3'b000, PW, 12'h000, 3'b000, 3'b000, 0);
      step(4'd12, 0, 0, 0, 0, 3'b000, PW, 12'h000, 3'b000, 3'b000, 0);
      step(4'd12, 0, 0, 0, 0, 3'b010, PW, 12'h000, 3'b000, 3'b000, 0);
      step(4'd12, 0, 0, 0, 0, 3'b000, PE2, 12'h0A4, 3'b000, 3'b000, 0);
      // COP_0, ready never comes: 7 counting WAIT cycles, abort on the 8th
      step(4'd11, 0, 0, 0, 0, 3'b000, PF, 12'h002, 3'b000, 3'b000, 0);
      step(4'd11, 0, 0, 0, 0, 3'b000, PE1, 12'h100, 3'b001, 3'b000, 0);
      for (int i = 0; i < 7; i++) begin
         step(4'd11, 0, 0, 0, 0, 3'b000, PW, 12'h000, 3'b000, 3'b000, 0);
      end
      step(4'd11, 0, 0, 0, 0, 3'b000, PW, 12'h000, 3'b000, 3'b001, 0);
      exp_err = 1'b1;
      step(4'd11, 0, 0, 0, 0, 3'b000, PE2, 12'h004, 3'b000, 3'b000, 0);
      // STP, stalled resume, lone resume
      step(4'd7, 0, 0, 0, 0, 3'b000, PF, 12'h002, 3'b000, 3'b000, 0);
      step(4'd7, 0, 0, 0, 0, 3'b000, PE1, 12'h000, 3'b000, 3'b000, 0);
      step(4'd7, 0, 0, 0, 0, 3'b000, PH, 12'h000, 3'b000, 3'b000, 0);
      step(4'd7, 0, 0, 1, 1, 3'b000, PH, 12'h000, 3'b000, 3'b000, 0);
      step(4'd7, 0, 0, 1, 1, 3'b000, PH, 12'h000, 3'b000, 3'b000, 0);
      step(4'd7, 0, 0, 0, 1, 3'b000, PH, 12'h004, 3'b000, 3'b000, 0);
      // LDI with one stalled EXEC1 cycle
      step(4'd8, 0, 0, 0, 0, 3'b000, PF, 12'h002, 3'b000, 3'b000, 0);
      step(4'd8, 0, 0, 1, 0, 3'b000, PE1, 12'h000, 3'b000, 3'b000, 0);
      step(4'd8, 0, 0, 0, 0, 3'b000, PE1, 12'h4A4, 3'b000, 3'b000, 0);
      // ADD, STA, LSL, LSR, JMI not taken
      step(4'd2, 0, 0, 0, 0, 3'b000, PF, 12'h002, 3'b000, 3'b000, 0);
      step(4'd2, 0, 0, 0, 0, 3'b000, PE1, 12'h100, 3'b000, 3'b000, 0);
      step(4'd2, 0, 0, 0, 0, 3'b000, PE2, 12'h0B4, 3'b000, 3'b000, 0);
      step(4'd1, 0, 0, 0, 0, 3'b000, PF, 12'h002, 3'b000, 3'b000, 0);
      step(4'd1, 0, 0, 0, 0, 3'b000, PE1, 12'h105, 3'b000, 3'b000, 0);
      step(4'd9, 0, 0, 0, 0, 3'b000, PF, 12'h002, 3'b000, 3'b000, 0);
      step(4'd9, 0, 0, 0, 0, 3'b000, PE1, 12'h2B4, 3'b000, 3'b000, 0);
      step(4'd10, 0, 0, 0, 0, 3'b000, PF, 12'h002, 3'b000, 3'b000, 0);
      step(4'd10, 0, 0, 0, 0, 3'b000, PE1, 12'h024, 3'b000, 3'b000, 0);
      step(4'd5, 0, 0, 0, 0, 3'b000, PF, 12'h002, 3'b000, 3'b000, 0);
      step(4'd5, 0, 0, 0, 0, 3'b000, PE1, 12'h004, 3'b000, 3'b000, 0);
      // Illegal opcode 15
      step(4'd15, 0, 0, 0, 0, 3'b000, PF, 12'h002, 3'b000, 3'b000, 0);
      step(4'd15, 0, 0, 0, 0, 3'b000, PE1, 12'h004, 3'b000, 3'b000, 1);
      // COP_2 with ready already high on the first WAIT cycle
      step(4'd13, 0, 0, 0, 0, 3'b000, PF, 12'h002, 3'b000, 3'b000, 0);
      step(4'd13, 0, 0, 0, 0, 3'b000, PE1, 12'h100, 3'b100, 3'b000, 0);
      step(4'd13, 0, 0, 0, 0, 3'b100, PW, 12'h000, 3'b000, 3'b000, 0);
      step(4'd13, 0, 0, 0, 0, 3'b000, PE2, 12'h0A4, 3'b000, 3'b000, 0);
      // COP_0 again, then asynchronous reset in the middle of WAIT
      step(4'd11, 0, 0, 0, 0, 3'b000, PF, 12'h002, 3'b000, 3'b000, 0);
      step(4'd11, 0, 0, 0, 0, 3'b000, PE1, 12'h100, 3'b001, 3'b000, 0);
      step(4'd11, 0, 0, 0, 0, 3'b000, PW, 12'h000, 3'b000, 3'b000, 0);
      #2;
      check("pre_reset.waiting", 32'(waiting), 32'h1);
      rst_n = 1'b0;
      #1 check_reset("mid_wait_reset");
      exp_err = 1'b0;
      @(posedge clk);
      #1 rst_n = 1'b1;

      for (int i = 0; i < 10 && exp_q.size() != 0; i++) begin
         @(negedge clk);
      end
      check("queue_drained", 32'(exp_q.size()), 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/control_sequencer.md
# control_sequencer

Parametrised successor to the CPU's combinational instruction decoder. It owns the fetch/execute phase state machine instead of taking phase strobes from outside, and decodes `op` plus the EQ/MI flags into the 12-bit datapath control word. It adds a generic start/ready handshake for `NUM_COP` coprocessor channels with a watchdog timeout, a memory stall input, and a halt/resume mechanism. It sits between the IR/flag registers and the PC, ACC, ALU, MUX and RAM write enables.

## Interface
- `OP_W`, 4: opcode width.
- `NUM_COP`, 3: coprocessor channels. Legal range is 1 to 2^OP_W−11.
- `TO_W`, 8: watchdog counter width. Timeout limit is 2^TO_W−1 cycles.
- `COP_WB`, 3'b110: per-channel mask. Bit k set means channel k writes its result to ACC in EXEC2.

Ports (clock and reset first):
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `op` in OP_W: opcode from IR. Must be stable from EXEC1 through the end of the instruction.
- `eq` in 1: accumulator-zero flag.
- `mi` in 1: accumulator-negative flag.
- `stall` in 1: memory not ready. Freezes the sequencer.
- `resume` in 1: leaves HALT.
- `cop_ready` in NUM_COP: per-channel done level.
- `control_port` out 12: datapath control word.
- `fetch`, `exec1`, `exec2`, `waiting`, `halted` out 1 each: one-hot phase indicators.
- `cop_start` out NUM_COP: one-cycle start pulse per channel.
- `cop_abort` out NUM_COP: one-cycle timeout pulse per channel.
- `err_timeout` out 1: sticky timeout flag. Cleared only by reset.
- `illegal_op` out 1: one-cycle pulse on an undefined opcode.

## Operation
- Opcodes:
  - 0 LDA, 1 STA, 2 ADD, 3 SUB
  - 4 JMP, 5 JMI, 6 JEQ, 7 STP
  - 8 LDI, 9 LSL, 10 LSR
  - 11+k COP_k, for k < NUM_COP
  - All higher opcodes are illegal.
- State transitions:
  - FETCH → EXEC1, always.
  - EXEC1 → EXEC2 for LDA, ADD, SUB.
  - EXEC1 → WAIT for COP_k.
  - EXEC1 → HALT for STP.
  - EXEC1 → FETCH for everything else.
  - EXEC2 → FETCH.
  - WAIT → EXEC2 when `cop_ready[k]` is high or the watchdog expires.
  - HALT → FETCH on `resume`.
- Control word bits. Each bit is decoded combinationally from state, `op`, `eq` and `mi`:
  - [0] ram_wren: STA·E1.
  - [1] ir_en: FETCH.
  - [2] pc_cnt_en:
    - E1 for STA, JMI·¬mi, JEQ·¬eq, LDI, LSL, LSR and illegal opcodes.
    - E2 for LDA, ADD, SUB, COP.
    - HALT·resume.
  - [3] pc_sload: E1 for JMP, JMI·mi, JEQ·eq.
  - [4] alu_add: ADD·E2, LSL·E1.
  - [5] acc_en: E2 for LDA, ADD, SUB, and COP_k when COP_WB[k] is set and the channel did not time out; E1 for LDI, LSL, LSR.
  - [6] acc_shiftin: always 0.
  - [7] acc_load: same as [5], excluding LSR.
  - [8] mux1_sel: E1 for LDA, STA, ADD, SUB, JMP, JMI·mi, JEQ·eq, COP.
  - [9] lsl: LSL·E1.
  - [10] mux3_sel: LDA·E2, LDI·E1.
  - [11] lda_sig: LDA·E2.
- `cop_start[k]` is asserted for COP_k in EXEC1 only, exactly one cycle per instruction.
- Watchdog:
  - The counter clears on entry to WAIT.
  - It increments on each WAIT cycle where `cop_ready[k]` is low.
  - When it reaches 2^TO_W−1 with ready still low, the sequencer pulses `cop_abort[k]`, sets `err_timeout`, and moves to EXEC2 with writeback suppressed. pc_cnt_en is still asserted.
  - If ready and expiry occur in the same cycle, ready wins: no abort, normal writeback.
- `illegal_op` pulses in EXEC1 on an undefined opcode. The instruction is treated as a NOP and the PC increments.
- `stall` high:
  - State, watchdog counter and `err_timeout` hold.
  - `control_port`, `cop_start` and `cop_abort` are forced to 0.
  - Phase outputs still show the current state.
- `resume` has no effect outside HALT. `stall` has priority over `resume`.

## Timing
- Reset (`rst_n` low, asynchronous):
  - State is FETCH and the counter is 0.
  - `fetch`=1 and `control_port`=12'h002.
  - All other outputs are 0.
- All outputs are combinational from the state register and inputs. State advances on the rising edge of `clk`.
- Instruction cycle counts with no stall:
  - 2 cycles: STA, JMP, JMI, JEQ, LDI, LSL, LSR, illegal opcodes.
  - 3 cycles: LDA, ADD, SUB.
  - 3 + w cycles: COP, where w ≥ 1 is the number of WAIT cycles. The ready-in-first-WAIT case gives 4.
  - Maximum COP length is 3 + 2^TO_W cycles.
- `cop_ready` is sampled only in WAIT. A level that is already high on the first WAIT cycle ends WAIT after that one cycle.
- Each stall cycle adds exactly one cycle to the current phase.

## Test plan
- Reset, then LDA: phases FETCH → E1 → E2 → FETCH. Required control words: 12'h002, then 12'h100, then 12'hCA4.
- JEQ with eq=1, then with eq=0: E1 word is 12'h108 for eq=1 and 12'h004 for eq=0. Both return to FETCH in 2 cycles.
- COP_1 with ready rising on the 3rd WAIT cycle:
  - `cop_start`=3'b010 for one cycle.
  - 3 WAIT cycles, then E2 word 12'h0A4.
  - No abort.
- COP_0 with TO_W=3 and ready never asserted:
  - 7 WAIT cycles, then `cop_abort[0]` pulses and `err_timeout`=1.
  - E2 word is 12'h004.
  - `err_timeout` stays 1 until reset.
- STP, then `resume` together with `stall`, then `resume` alone:
  - `halted` holds throughout the stalled resume.
  - The lone resume cycle outputs 12'h004, then the sequencer returns to FETCH.
- Opcode 15 with OP_W=4, NUM_COP=3: `illegal_op` pulses, E1 word is 12'h004. Also assert `rst_n` mid-WAIT: all outputs return to reset values immediately.
